// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file and trap controller:
// CSR addresses, Zicsr op encoding, mcause codes, status/enable bit
// positions and mtvec modes, plus the read-modify-write helper.
package csr_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    // Zicsr operation carried on Di_csr_op
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    // mcause values
    localparam logic [31:0] MCAUSE_ILLEGAL   = 32'd2;
    localparam logic [31:0] MCAUSE_EBREAK    = 32'd3;
    localparam logic [31:0] MCAUSE_ECALL     = 32'd11;
    localparam logic [31:0] MCAUSE_IRQ_EXT   = 32'h8000_000B;
    localparam logic [31:0] MCAUSE_IRQ_TIMER = 32'h8000_0007;

    // mstatus / mie / mip bit positions
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MTIE     = 7;
    localparam int MIE_MEIE     = 11;

    // mtvec mode field
    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    // Value a Zicsr op would store given the old CSR contents
    function automatic logic [31:0] csr_apply(input csr_op_e op,
                                              input logic [31:0] old_v,
                                              input logic [31:0] wdata);
        case (op)
            CSR_OP_RW: return wdata;
            CSR_OP_RS: return old_v | wdata;
            CSR_OP_RC: return old_v & ~wdata;
            default:   return old_v;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with increment enable and independent
// 32-bit half writes. A half write wins over the increment and leaves the
// other half untouched. Wraps from all-ones to zero.
module csr_counter64 (
    input  logic        clk,
    input  logic        reset_x,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] cnt_o
);

    logic [63:0] cnt_q, cnt_d;

    // next count: half write has priority over increment
    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i)
            cnt_d[31:0] = wdata_i;
        else if (wr_hi_i)
            cnt_d[63:32] = wdata_i;
        else if (inc_i)
            cnt_d = cnt_q + 64'd1;
    end

    // counter register
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller for the single-hart RV32 core.
// Handles Zicsr accesses, synchronous exceptions, masked timer/external
// interrupts, mret and direct/vectored mtvec. Redirect and read data are
// combinational; all state updates land on the next clock edge.
// Optional feature macro: CSR_COUNTERS_EN adds mcycle/minstret (64-bit).
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        reset_x,
    input  logic [31:0] Di_PC,
    input  logic [1:0]  Di_csr_op,
    input  logic [11:0] Di_csr_addr,
    input  logic [31:0] Di_csr_wdata,
    input  logic        Di_ecall,
    input  logic        Di_ebreak,
    input  logic        Di_illegal,
    input  logic        Di_mret,
    input  logic        Di_retire,
    input  logic        Di_irq_timer,
    input  logic        Di_irq_ext,
    output logic [31:0] Do_csr_rdata,
    output logic        Do_csr_bad,
    output logic        Do_redirect,
    output logic [31:0] Do_redirect_pc,
    output logic [31:0] Do_mepc
);

    // Architectural state; only the implemented status/enable bits exist
    logic        mst_mie_q,  mst_mie_d;
    logic        mst_mpie_q, mst_mpie_d;
    logic        mtie_q,     mtie_d;
    logic        meie_q,     meie_d;
    logic [31:0] mtvec_q,    mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q,     mepc_d;
    logic [31:0] mcause_q,   mcause_d;

    csr_op_e     op;
    logic [31:0] rd_val;
    logic        csr_known;
    logic [31:0] wr_val;
    logic        irq_ext, irq_tmr, exc, trap, is_irq, do_mret, csr_wr;
    logic [31:0] cause;
    logic [31:0] trap_pc;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle, minstret;
`endif

    assign op = csr_op_e'(Di_csr_op);

    // CSR read decode; unknown addresses read zero
    always_comb begin
        rd_val    = '0;
        csr_known = 1'b1;
        case (Di_csr_addr)
            CSR_MSTATUS:   rd_val = {19'b0, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
            CSR_MIE:       rd_val = {20'b0, meie_q, 3'b0, mtie_q, 7'b0};
            CSR_MTVEC:     rd_val = mtvec_q;
            CSR_MSCRATCH:  rd_val = mscratch_q;
            CSR_MEPC:      rd_val = mepc_q;
            CSR_MCAUSE:    rd_val = mcause_q;
            CSR_MIP:       rd_val = {20'b0, Di_irq_ext, 3'b0, Di_irq_timer, 7'b0};
            CSR_MHARTID:   rd_val = HART_ID;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    rd_val = mcycle[31:0];
            CSR_MCYCLEH:   rd_val = mcycle[63:32];
            CSR_MINSTRET:  rd_val = minstret[31:0];
            CSR_MINSTRETH: rd_val = minstret[63:32];
`endif
            default:       csr_known = 1'b0;
        endcase
    end

    // Event arbitration: exceptions, then interrupts, then mret, then CSR write
    always_comb begin
        irq_ext = mst_mie_q && meie_q && Di_irq_ext;
        irq_tmr = mst_mie_q && mtie_q && Di_irq_timer;
        exc     = Di_illegal || Di_ebreak || Di_ecall;
        trap    = exc || irq_ext || irq_tmr;
        is_irq  = !exc && (irq_ext || irq_tmr);
        if (Di_illegal)     cause = MCAUSE_ILLEGAL;
        else if (Di_ebreak) cause = MCAUSE_EBREAK;
        else if (Di_ecall)  cause = MCAUSE_ECALL;
        else if (irq_ext)   cause = MCAUSE_IRQ_EXT;
        else                cause = MCAUSE_IRQ_TIMER;
        // vectored mode offsets interrupts only, by 4 x cause code
        trap_pc = {mtvec_q[31:2], 2'b00};
        if (is_irq && mtvec_q[1:0] == MTVEC_VECTORED)
            trap_pc = trap_pc + {25'b0, cause[4:0], 2'b00};
        do_mret = Di_mret && !trap;
        csr_wr  = (op != CSR_OP_NONE) && !trap && !do_mret && csr_known;
        wr_val  = csr_apply(op, rd_val, Di_csr_wdata);
    end

    // Outputs are forced quiet while reset is held; read data still decodes
    always_comb begin
        Do_csr_rdata   = rd_val;
        Do_csr_bad     = reset_x && !csr_known;
        Do_redirect    = reset_x && (trap || do_mret);
        Do_redirect_pc = '0;
        if (reset_x) begin
            if (trap)         Do_redirect_pc = trap_pc;
            else if (do_mret) Do_redirect_pc = mepc_q;
        end
        Do_mepc = mepc_q;
    end

    // Next architectural state
    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mtie_d     = mtie_q;
        meie_d     = meie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (trap) begin
            mepc_d     = Di_PC & ~32'h3;
            mcause_d   = cause;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
        end else if (do_mret) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end else if (csr_wr) begin
            case (Di_csr_addr)
                CSR_MSTATUS: begin
                    mst_mie_d  = wr_val[MSTATUS_MIE];
                    mst_mpie_d = wr_val[MSTATUS_MPIE];
                end
                CSR_MIE: begin
                    mtie_d = wr_val[MIE_MTIE];
                    meie_d = wr_val[MIE_MEIE];
                end
                // reserved modes (1x) collapse to direct
                CSR_MTVEC:    mtvec_d = {wr_val[31:2],
                                         (wr_val[1:0] == MTVEC_VECTORED) ? MTVEC_VECTORED : MTVEC_DIRECT};
                CSR_MSCRATCH: mscratch_d = wr_val;
                CSR_MEPC:     mepc_d     = wr_val & ~32'h3;
                CSR_MCAUSE:   mcause_d   = wr_val;
                default: ;
            endcase
        end
    end

    // CSR state registers
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b1;
            mtie_q     <= 1'b0;
            meie_q     <= 1'b0;
            mtvec_q    <= {MTVEC_RESET[31:2],
                           (MTVEC_RESET[1:0] == MTVEC_VECTORED) ? MTVEC_VECTORED : MTVEC_DIRECT};
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mtie_q     <= mtie_d;
            meie_q     <= meie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

`ifdef CSR_COUNTERS_EN
    csr_counter64 u_mcycle (
        .clk     (clk),
        .reset_x (reset_x),
        .inc_i   (1'b1),
        .wr_lo_i (csr_wr && Di_csr_addr == CSR_MCYCLE),
        .wr_hi_i (csr_wr && Di_csr_addr == CSR_MCYCLEH),
        .wdata_i (wr_val),
        .cnt_o   (mcycle)
    );

    // a trapping instruction does not retire
    csr_counter64 u_minstret (
        .clk     (clk),
        .reset_x (reset_x),
        .inc_i   (Di_retire && !trap),
        .wr_lo_i (csr_wr && Di_csr_addr == CSR_MINSTRET),
        .wr_hi_i (csr_wr && Di_csr_addr == CSR_MINSTRETH),
        .wdata_i (wr_val),
        .cnt_o   (minstret)
    );
`else
    logic unused_retire;
    assign unused_retire = Di_retire;
`endif

endmodule

// File: doc/csr_trap_unit.md
# csr_trap_unit

Machine-mode CSR file and trap controller for the single-hart RV32 core; the next generation of the ecall/mret-only exception handler. It adds Zicsr read/write access, synchronous exceptions (ecall, ebreak, illegal), masked timer/external interrupts, direct/vectored mtvec and optional 64-bit performance counters. It sits beside the decoder/datapath: the controller supplies event strobes, the datapath supplies PC and CSR operands, and the block returns trap redirect and CSR read data.

## Interface
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec; bits [1:0] give the mode.
- HART_ID, 0, constant value returned by mhartid.
- clk  in  1  clock
- reset_x  in  1  asynchronous, active-low reset
- Di_PC  in  32  PC of the instruction in execute
- Di_csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC
- Di_csr_addr  in  12  CSR address
- Di_csr_wdata  in  32  rs1 value or zero-extended uimm
- Di_ecall, Di_ebreak, Di_illegal, Di_mret  in  1 each  decoded event strobes
- Di_retire  in  1  instruction completes this cycle
- Di_irq_timer, Di_irq_ext  in  1 each  level interrupt lines
- Do_csr_rdata  out  32  old CSR value, combinational
- Do_csr_bad  out  1  unknown CSR address (controller raises Di_illegal)
- Do_redirect  out  1  trap or mret redirect this cycle
- Do_redirect_pc  out  32  fetch target when Do_redirect=1
- Do_mepc  out  32  current mepc

## Operation
- Implemented CSRs: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344 (read-only), mhartid 0xF14 (read-only).
- mstatus: only MIE[3], MPIE[7], MPP[12:11] exist. MPP is hardwired to 11, and all other bits read 0. Reset value 0x0000_1880.
- mie: only MTIE[7] and MEIE[11] are writable. mip reads {MEIP[11]=Di_irq_ext, MTIP[7]=Di_irq_timer}.
- mepc[1:0] is hardwired to 0. The mtvec mode field accepts only 00/01; a write of 1x stores 00.
- Reset values: mepc, mcause, mscratch, mie = 0; mtvec = MTVEC_RESET. All outputs are 0 during reset, except Do_csr_rdata, which follows the address decode.
- Event priority within one cycle, highest first:
  - Di_illegal
  - Di_ebreak
  - Di_ecall
  - pending interrupt: external before timer, taken only when MIE=1, the mie bit is set and the line is high
  - Di_mret
  - CSR write
- Trap entry (any exception or interrupt):
  - mepc ← Di_PC. Software advances mepc itself; there is no +4.
  - mcause ← 2, 3 or 11 for illegal, ebreak or ecall; 0x8000_000B for external, 0x8000_0007 for timer.
  - MPIE ← MIE, then MIE ← 0.
  - The CSR write and counter retire increment are suppressed in that cycle.
- Trap target:
  - Do_redirect_pc = {mtvec[31:2],2'b00}.
  - In vectored mode (mode 01) with an interrupt cause, add 4×(cause code).
- mret: MIE ← MPIE, MPIE ← 1, Do_redirect_pc = mepc.
- CSR write, when Di_csr_op≠00 with no trap and no bad address:
  - RW stores wdata.
  - RS stores old|wdata.
  - RC stores old&~wdata.
  - Writes to read-only CSRs are ignored silently.
- Unknown address: Do_csr_rdata=0, Do_csr_bad=1, no state change.

## Timing
- Do_redirect, Do_redirect_pc, Do_csr_rdata and Do_csr_bad are combinational from the current inputs and state.
- All CSR updates land on the next posedge clk. A CSR read in cycle N+1 sees a write or trap from cycle N.
- An interrupt line must stay high until taken; the block does not latch it.
- Reset asserted mid-operation clears all state on the reset edge, regardless of pending events.

## Configuration
- CSR_COUNTERS_EN defined:
  - Adds mcycle/mcycleh (0xB00/0xB80) and minstret/minstreth (0xB02/0xB82).
  - Each is 64-bit, reset 0, and wraps from 2^64−1 to 0.
  - mcycle increments every cycle. minstret increments when Di_retire=1 and no trap occurs.
  - A CSR write to either half wins over the increment in that cycle; the other half holds.
- CSR_COUNTERS_EN undefined: these addresses decode as unknown (Do_csr_bad=1) and no counter flops exist.

## Structure
- Package csr_pkg holds:
  - CSR address constants
  - csr_op encoding
  - mcause codes
  - mstatus/mie bit positions
  - mtvec mode constants
- Sub-module csr_counter64 (64-bit counter with increment enable and per-half write) is instantiated twice under CSR_COUNTERS_EN.

## Test plan
- Reset → mstatus reads 0x1880, mtvec reads MTVEC_RESET, mepc reads 0, Do_redirect=0.
- csrrw mtvec=0x100, then Di_ecall at PC 0x40 → Do_redirect_pc=0x100; next cycle mepc=0x40, mcause=11, MIE=0, MPIE=prior MIE.
- mtvec=0x101, mie=0x80, MIE=1, Di_irq_timer=1 → Do_redirect_pc=0x11C, mcause=0x8000_0007; Di_illegal in the same cycle instead gives mcause=2 and target 0x100.
- csrrs mstatus wdata 0x8, then csrrc mstatus wdata 0x8 → reads 0x1888, then 0x1880; a write of 0xFFFF_FFFF to mip or mhartid leaves both unchanged.
- Di_mret with MPIE=1, mepc=0x200 → Do_redirect_pc=0x200; next cycle MIE=1, MPIE=1. Access to 0x7C0 → Do_csr_bad=1, rdata 0.
- With CSR_COUNTERS_EN: write mcycle=0xFFFF_FFFF, mcycleh=0xFFFF_FFFF → after one cycle both read 0. Di_retire with a simultaneous ecall → minstret unchanged.
